// File: rtl/proc_control.sv
// Control FSM for the basic CPU datapath: steps each instruction through T0..T3 and
// drives the bus select, register/IR/A/G load enables, ALU mode and done.
module proc_control #(
    parameter int unsigned K    = 9,
    parameter int unsigned IR_W = 9
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    output logic [K:0]      select,
    output logic [K-2:0]    reg_in,
    output logic            ir_in,
    output logic            a_in,
    output logic            g_in,
    output logic            addsub,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {StT0, StT1, StT2, StT3} state_e;

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;

    localparam logic [K-2:0] RegOne = 1;
    localparam logic [K:0]   SelDin = 1;
    localparam logic [K:0]   SelG   = 2;

    state_e state_q, state_d;

    logic [2:0]   opcode;
    logic [2:0]   rx;
    logic [2:0]   ry;
    logic [K-2:0] dec_x;
    logic [K-2:0] dec_y;

    assign opcode = ir[IR_W-1 -: 3];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign dec_x  = RegOne << rx;
    assign dec_y  = RegOne << ry;

    always_comb begin
        state_d = state_q;
        select  = '0;
        reg_in  = '0;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            StT0: begin
                ir_in = run;
                if (run) state_d = StT1;
            end
            StT1: begin
                busy = 1'b1;
                case (opcode)
                    OpMv: begin
                        select  = {dec_y, 2'b00};
                        reg_in  = dec_x;
                        done    = 1'b1;
                        state_d = StT0;
                    end
                    OpMvi: begin
                        select  = SelDin;
                        reg_in  = dec_x;
                        done    = 1'b1;
                        state_d = StT0;
                    end
                    OpAdd, OpSub: begin
                        select  = {dec_x, 2'b00};
                        a_in    = 1'b1;
                        state_d = StT2;
                    end
                    default: begin
                        done    = 1'b1;
                        state_d = StT0;
                    end
                endcase
            end
            StT2: begin
                busy    = 1'b1;
                select  = {dec_y, 2'b00};
                g_in    = 1'b1;
                addsub  = (opcode == OpSub);
                state_d = StT3;
            end
            StT3: begin
                busy    = 1'b1;
                select  = SelG;
                reg_in  = dec_x;
                done    = 1'b1;
                state_d = StT0;
            end
            // Unknown state: behave as idle with every output low.
            default: state_d = StT0;
        endcase

        if (reset) begin
            state_d = StT0;
            select  = '0;
            reg_in  = '0;
            ir_in   = 1'b0;
            a_in    = 1'b0;
            g_in    = 1'b0;
            addsub  = 1'b0;
            done    = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= StT0;
        else       state_q <= state_d;
    end

endmodule
